float_to_fixed_iter: RTL
========================

// Module: float_to_fixed_iter
// PURPOSE
//   Converts IEEE-754 single precision to 22-bit sign-magnitude fixed point
//   (1 sign, 1 integer, FRAC_BITS=20 fraction bits), the same format used on the fixed side of the
//   conversion path. It is the return stage after float arithmetic, feeding fixed-point consumers.
//   Iterative right shifter under an FSM; valid/ready on both sides; one conversion in flight.
// PARAMETERS
//   FRAC_BITS   20  fraction bits of fixed output (output width = FRAC_BITS+2)
//   SHIFT_STEP  1   max bits shifted per cycle; power of two, 1..8
// PORTS
//   clk        in   1   single clock, all state on rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block can accept (high only in IDLE)
//   in_data    in   32  IEEE-754 single {s, e[7:0], m[22:0]}
//   out_valid  out  1   out_data/flags valid, held until out_ready
//   out_ready  in   1   consumer accepts
//   out_data   out  22  {sign, int bit, frac[19:0]}, value=(-1)^s*mag/2^20
//   out_ovf    out  1   |x|>=2 or Inf: saturated
//   out_nan    out  1   input was NaN
//   out_inexact out 1   nonzero bits discarded (truncation/underflow)
// BEHAVIOUR
//   Reset: state=IDLE, out_valid=0, out_data=0, all flags=0; any in-flight op discarded.
//   States: IDLE -> (accept) -> SHIFT or DONE; SHIFT -> DONE when cnt==0; DONE -> IDLE on out_valid&&out_ready.
//   Accept = in_valid && in_ready. in_ready = (state==IDLE); no accept in SHIFT/DONE.
//   Classification on accept (shamt = 3 + 127 - e):
//     e==255, m!=0 : NaN -> out_data=0, nan=1, go DONE
//     e==255, m==0 or e>=128 : sat -> out_data={s,21'h1FFFFF}, ovf=1, go DONE
//     e==0 : zero/denormal flushed -> out_data=0, inexact=(m!=0), go DONE
//     shamt>=24 : underflow -> out_data=0, inexact=1, go DONE
//     else : mag={1,m} (24b), cnt=shamt (3..23), go SHIFT
//   SHIFT: each edge mag>>=min(SHIFT_STEP,cnt), cnt-=same, sticky|=bits shifted out; cnt==0 after edge -> DONE.
//   DONE: out_data={s,mag[20:0]}, inexact=sticky; all outputs stable while out_ready low.
//   Rounding: truncation toward zero only. Zero magnitude result always has sign=0 (no -0).
//   Latency (accept edge to out_valid high): specials 1 edge; normal 1+ceil(shamt/SHIFT_STEP) edges.
//   Throughput: next accept no earlier than cycle after output handshake.
//   Simultaneous rst with any handshake: rst wins, handshake ignored.
//   out_ready high while not out_valid: ignored.
// STRUCTURE
//   Shared package conv_pkg: FLT_BIAS=127, FLT_EXP_W=8, FLT_MAN_W=23, FIX_W=22,
//   FIX_FRAC=20, state encodings IDLE/SHIFT/DONE.
//   One sub-module: float_classify (combinational: NaN/Inf/sat/zero/underflow decode + shamt).
//   FSM, shift register, counter, sticky in the top module.
// TESTING
//   0x3F800000 (1.0) -> 0x100000, flags 0, out_valid 4 edges after accept (STEP=1)
//   0xBF400000 (-0.75) -> 0x2C0000, inexact 0; 0x34000000 (2^-23*... e=104) -> 0, inexact 1
//   0x40000000 (2.0) -> 0x1FFFFF ovf=1; 0xC0600000 (-3.5) -> 0x3FFFFF ovf=1; 0x7F800000 -> 0x1FFFFF ovf=1
//   0x7FC00000 -> 0, nan=1; 0x80000000 (-0) -> 0x000000, flags 0; 0x35800000 (2^-20) -> 0x000001
//   0x3F800001 -> 0x100000 inexact=1; out_ready low 5 cycles -> data/flags held, in_ready low
//   rst asserted mid-SHIFT -> next edge IDLE, out_valid 0, in_ready 1; SHIFT_STEP=4 latency check

Source files
------------

// File: rtl/conv_pkg.sv
// Shared float/fixed conversion constants, FSM state encoding and the
// classification record passed from the decoder to the converter.
package conv_pkg;

  localparam int FLT_BIAS  = 127;
  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAN_W = 23;
  localparam int FIX_W     = 22;
  localparam int FIX_FRAC  = 20;
  localparam int MAG_W     = FLT_MAN_W + 1;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic             nan;
    logic             sat;
    logic             zero;
    logic             unf;
    logic             sign;
    logic [MAG_W-1:0] mant;
    logic [CNT_W-1:0] shamt;
  } class_t;

endpackage

// File: rtl/float_classify.sv
// Combinational decode of a single-precision word into special-case flags,
// the 24-bit significand with hidden bit, and the right-shift amount.
module float_classify
  import conv_pkg::*;
#(
  parameter int FRAC_BITS = FIX_FRAC
) (
  input  logic [31:0] data,
  output class_t      cls
);

  localparam int SH_BASE = FLT_MAN_W - FRAC_BITS + FLT_BIAS;

  logic [FLT_EXP_W-1:0] e;
  logic [FLT_MAN_W-1:0] m;
  logic [9:0]           sh_full;

  assign e = data[30:23];
  assign m = data[22:0];
  // Wraps for e above the bias, but those inputs are caught as saturation first.
  assign sh_full = 10'(SH_BASE) - {2'b00, e};

  always_comb begin
    cls       = '0;
    cls.sign  = data[31];
    cls.mant  = {1'b1, m};
    cls.shamt = sh_full[CNT_W-1:0];
    if (e == 8'hFF && m != '0) begin
      cls.nan = 1'b1;
    end else if (e >= 8'd128) begin
      cls.sat = 1'b1;
    end else if (e == 8'd0) begin
      cls.zero = 1'b1;
    end else if (sh_full >= 10'(MAG_W)) begin
      cls.unf = 1'b1;
    end
  end

endmodule

// File: rtl/float_to_fixed_iter.sv
// Float32 to sign-magnitude fixed point (1 int bit, FRAC_BITS fraction) by an
// iterative right shifter; one conversion in flight, truncating toward zero.
module float_to_fixed_iter
  import conv_pkg::*;
#(
  parameter int FRAC_BITS  = FIX_FRAC,
  parameter int SHIFT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAC_BITS+1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_nan,
  output logic                 out_inexact
);

  state_t           state, state_nxt;
  class_t           cls;
  logic [MAG_W-1:0] mag, mag_shr, lost_mask;
  logic [CNT_W-1:0] cnt, step;
  logic [FRAC_BITS:0] mag_out;
  logic             sign, sticky, ovf, nan, accept, special;

  float_classify #(.FRAC_BITS(FRAC_BITS)) u_classify (
    .data (in_data),
    .cls  (cls)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign special   = cls.nan || cls.sat || cls.zero || cls.unf;

  always_comb begin
    step      = (cnt < CNT_W'(SHIFT_STEP)) ? cnt : CNT_W'(SHIFT_STEP);
    mag_shr   = mag >> step;
    lost_mask = ~({MAG_W{1'b1}} << step);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : SHIFT;
      SHIFT:   if (cnt == step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      sticky <= 1'b0;
      ovf    <= 1'b0;
      nan    <= 1'b0;
    end else if (accept) begin
      sign   <= cls.sign;
      cnt    <= cls.shamt;
      sticky <= 1'b0;
      ovf    <= 1'b0;
      nan    <= 1'b0;
      if (cls.nan) begin
        mag <= '0;
        nan <= 1'b1;
      end else if (cls.sat) begin
        mag <= MAG_W'({(FRAC_BITS+1){1'b1}});
        ovf <= 1'b1;
      end else if (cls.zero) begin
        mag    <= '0;
        sticky <= (cls.mant[FLT_MAN_W-1:0] != '0);
      end else if (cls.unf) begin
        mag    <= '0;
        sticky <= 1'b1;
      end else begin
        mag <= cls.mant;
      end
    end else if (state == SHIFT) begin
      mag    <= mag_shr;
      cnt    <= cnt - step;
      sticky <= sticky | (|(mag & lost_mask));
    end
  end

  // Sign is dropped on a zero magnitude so -0 never reaches consumers.
  assign mag_out     = mag[FRAC_BITS:0];
  assign out_data    = {sign && (mag_out != '0), mag_out};
  assign out_ovf     = ovf;
  assign out_nan     = nan;
  assign out_inexact = sticky;

endmodule
